// File: rtl/io_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : io_config_loader
// Description : Serial configuration loader for an I/O block. Shifts CFG_W
//               bits in MSB-first under a valid/ready handshake and commits
//               the completed frame to the parallel select word c.
//               Optional even-parity check enabled by macro IO_CFG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_config_loader #(
    parameter int WS     = 6,
    parameter int WD     = 3,
    parameter int WG     = 3,
    parameter int EXTIN  = 3,
    parameter int EXTOUT = 3,
    parameter int CFG_W  = $clog2(EXTIN) * (WS + WD + WG) + $clog2(WS + WD) * EXTOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [CFG_W-1:0] c,
    output logic             cfg_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int c_CNT_W = $clog2(CFG_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CFG_W - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_COMMIT = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CFG_W-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic [CFG_W-1:0]   r_c;
    logic               r_done;
    logic               w_ready;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_start;

`ifdef IO_CFG_PARITY_EN
    logic               r_err;
    logic               w_par_ok;
    logic               w_par_fail;

    // Even parity: data bits XOR the trailing parity bit must be zero.
    assign w_par_ok = ~((^r_shift) ^ cfg_bit);
`endif

    // Abort takes precedence over a simultaneous valid bit.
    assign w_accept   = cfg_valid && w_ready && !cfg_abort;
    assign w_last_bit = (r_cnt == c_LAST);
    assign w_start    = (r_state == c_IDLE) && cfg_start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake ready.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
`ifdef IO_CFG_PARITY_EN
        w_par_fail  = 1'b0;
`endif
        case (r_state)
            c_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                w_ready = 1'b1;
                if (cfg_abort) begin
                    w_state_nxt = c_IDLE;
                end else if (cfg_valid && w_last_bit) begin
`ifdef IO_CFG_PARITY_EN
                    w_state_nxt = c_PARITY;
`else
                    w_state_nxt = c_COMMIT;
`endif
                end
            end
            c_PARITY: begin
`ifdef IO_CFG_PARITY_EN
                w_ready = 1'b1;
                if (cfg_abort) begin
                    w_state_nxt = c_IDLE;
                end else if (cfg_valid) begin
                    if (w_par_ok) begin
                        w_state_nxt = c_COMMIT;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_par_fail  = 1'b1;
                    end
                end
`else
                // Unreachable without parity; recover to IDLE.
                w_state_nxt = c_IDLE;
`endif
            end
            c_COMMIT: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Shift path, bit counter, committed word and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            // done rises on the same edge that makes the new c visible.
            r_done <= (r_state == c_COMMIT);
            if (w_start) begin
                r_cnt <= '0;
            end else if ((r_state == c_SHIFT) && w_accept) begin
                r_shift <= {r_shift[CFG_W-2:0], cfg_bit};
                r_cnt   <= r_cnt + 1'b1;
            end
            if (r_state == c_COMMIT) begin
                r_c <= r_shift;
            end
        end
    end

`ifdef IO_CFG_PARITY_EN
    // Sticky parity error, cleared by reset or by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_par_fail) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign cfg_ready = w_ready;
    assign c         = r_c;
    assign cfg_out   = r_shift[CFG_W-1];
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_io_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_config_loader
// Description : Directed self-checking bench for io_config_loader. Expected
//               committed words are queued when a frame is driven and popped
//               when done is observed. Parity cases under IO_CFG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_config_loader;

    localparam int CFG_W = 36;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic             cfg_abort;
    logic             cfg_bit;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] c;
    logic             cfg_out;
    logic             busy;
    logic             done;
    logic             err;

    int               vectors     = 0;
    int               miscompares = 0;
    int               cycles      = 0;
    logic [CFG_W-1:0] sb_q[$];
    logic [CFG_W-1:0] last_c = '0;
    bit               mon_en = 1'b0;

    io_config_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .c         (c),
        .cfg_out   (cfg_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards the scoreboard monitor inspects c and done.
    task automatic tick();
        logic rst_at_edge;
        rst_at_edge = rst;
        @(posedge clk);
        #1;
        cycles++;
        if (mon_en) begin
            if (rst_at_edge) begin
                check("c_reset", c, 0);
                last_c = '0;
            end else if (done) begin
                check("busy_at_done", busy, 0);
                if (sb_q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    last_c = sb_q.pop_front();
                    check("c_commit", c, last_c);
                end
            end else begin
                check("c_hold", c, last_c);
            end
        end
    endtask

    task automatic send_bits(input logic [CFG_W-1:0] f, input int n, input bit stall, input int glitch);
        for (int i = 0; i < n; i++) begin
            cfg_bit   = f[CFG_W-1-i];
            cfg_valid = 1'b1;
            cfg_start = (i == glitch);
            check("ready_in_shift", cfg_ready, 1);
            tick();
            cfg_start = 1'b0;
            if (stall && (i != n - 1)) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~cfg_bit;
                tick();
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [CFG_W-1:0] f, input bit stall, input bit abort_commit, input int glitch);
        int t0;
        sb_q.push_back(f);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        t0 = cycles;
        check("busy_after_start", busy, 1);
        check("err_after_start", err, 0);
        send_bits(f, CFG_W, stall, glitch);
        check("busy_in_commit", busy, 1);
        check("ready_in_commit", cfg_ready, 0);
        check("cfg_out_msb", cfg_out, f[CFG_W-1]);
        cfg_valid = stall;
        cfg_bit   = ~f[0];
        cfg_abort = abort_commit;
        tick();
        check("done_pulse", done, 1);
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        if (stall) begin
            check("stall_cycles", (cycles - t0 >= 72), 1);
        end
        tick();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        tick();
        check("rst_c", c, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cfg_out", cfg_out, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Valid bits while idle are ignored.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready", cfg_ready, 0);
        end
        cfg_valid = 1'b0;

        // Straight load without stalls.
        load_frame(36'hA5A5A5A5A, 1'b0, 1'b0, -1);

        // Abort after 20 bits; abort and valid together drop the bit.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(36'hFFFFFFFFF, 20, 1'b0, -1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 0);
        tick();
        check("abort_no_done", done, 0);

        // Full load; a start pulse mid-frame must not restart the count.
        load_frame(36'h123456789, 1'b0, 1'b0, 5);

        // Same frame as the first, valid toggling every other cycle.
        load_frame(36'hA5A5A5A5A, 1'b1, 1'b0, -1);

        // Reset at bit 10 discards the partial frame.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(36'h0F0F0F0F0, 10, 1'b0, -1);
        rst       = 1'b1;
        cfg_valid = 1'b1;
        tick();
        rst       = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cfg_ready, 0);
        check("mid_rst_cfg_out", cfg_out, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        tick();
        check("post_rst_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        // Fresh load after reset; abort during COMMIT is ignored.
        load_frame(36'hFFFFFFFFF, 1'b0, 1'b1, -1);

`ifdef IO_CFG_PARITY_EN
        // Bad parity: no commit, sticky error.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bits(36'h000000001, CFG_W, 1'b0, -1);
        check("parity_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("par_bad_err", err, 1);
        check("par_bad_busy", busy, 0);
        tick();
        check("par_bad_no_done", done, 0);
        check("par_err_sticky", err, 1);

        // Good parity: commits, error cleared by the start.
        sb_q.push_back(36'h000000001);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("par_err_cleared", err, 0);
        send_bits(36'h000000001, CFG_W, 1'b0, -1);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("par_good_busy", busy, 1);
        tick();
        check("par_good_done", done, 1);
        check("par_good_err", err, 0);
`else
        check("err_tied_low", err, 0);
`endif

        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_config_loader.md
IO_CONFIG_LOADER -- requirements
Module: io_config_loader

Interface
REQ-001 Parameter WS, default 6: single-wire track count of the attached I/O block.
REQ-002 Parameter WD, default 3: double-wire track count.
REQ-003 Parameter WG, default 3: global line count.
REQ-004 Parameter EXTIN, default 3: external input count.
REQ-005 Parameter EXTOUT, default 3: external output count.
REQ-006 Parameter CFG_W, default clog2(EXTIN)*(WS+WD+WG)+clog2(WS+WD)*EXTOUT (36 at defaults): configuration frame width.
REQ-007 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1: synchronous, active-high reset.
REQ-009 Port cfg_start, input, 1: begin a new frame load.
REQ-010 Port cfg_abort, input, 1: abandon the frame in progress.
REQ-011 Port cfg_bit, input, 1: serial configuration data.
REQ-012 Port cfg_valid, input, 1: cfg_bit is valid this cycle.
REQ-013 Port cfg_ready, output, 1: loader accepts a bit this cycle.
REQ-014 Port c, output, CFG_W: committed configuration word driving the I/O block select inputs.
REQ-015 Port cfg_out, output, 1: MSB of the shift register, for daisy-chaining.
REQ-016 Port busy, output, 1: high in any state other than IDLE.
REQ-017 Port done, output, 1: one-cycle pulse coinciding with the first cycle a new c is visible.
REQ-018 Port err, output, 1: parity failure flag.

Function
REQ-019 The FSM SHALL have states IDLE, SHIFT, PARITY and COMMIT.
REQ-020 IDLE: cfg_start moves to SHIFT and clears the bit counter; cfg_ready=0.
REQ-021 SHIFT: cfg_ready=1; the bit is accepted when cfg_valid&&cfg_ready; shift <= {shift[CFG_W-2:0], cfg_bit}; counter increments, so the first bit lands in c[CFG_W-1].
REQ-022 Accepting bit number CFG_W-1 (0-based) moves SHIFT to PARITY when parity is enabled, otherwise to COMMIT.
REQ-023 COMMIT: at the next edge, c <= shift, done=1 for one cycle, state returns to IDLE; c visible two edges after the last data bit is accepted; cfg_ready=0.
REQ-024 cfg_valid with cfg_ready=0 is ignored; no bit is consumed.
REQ-025 cfg_abort in SHIFT or PARITY returns to IDLE next edge; c unchanged; done not pulsed.
REQ-026 cfg_abort with cfg_valid in the same cycle: abort wins, the bit is dropped.
REQ-027 cfg_start outside IDLE is ignored; cfg_abort in IDLE or COMMIT is ignored.
REQ-028 The counter width is clog2(CFG_W+1) and it never wraps; it is bounded by the transition in REQ-022.
REQ-029 c SHALL change only in COMMIT or on reset; between commits it is held stable.

Reset
REQ-030 rst has priority over all inputs: state=IDLE, shift=0, counter=0, c=0, done=0, err=0, busy=0, cfg_ready=0, cfg_out=0.
REQ-031 rst mid-frame discards partial data; the next load requires a fresh cfg_start.

Configuration
REQ-032 Macro IO_CFG_PARITY_EN defined: PARITY state accepts one extra bit under the same handshake; the XOR of the CFG_W data bits and the parity bit must be 0 (even parity). On match, go to COMMIT. On mismatch, go to IDLE, c unchanged, no done, err=1 (sticky until rst or the next accepted cfg_start).
REQ-033 Macro IO_CFG_PARITY_EN undefined: PARITY state is unreachable, SHIFT goes directly to COMMIT, err tied 0.

Verification
REQ-034 Reset, then start, then 36 bits of 0xA5A5A5A5A with no stalls -> c=36'hA5A5A5A5A, done high for exactly one cycle, busy falls with done.
REQ-035 Same frame with cfg_valid toggling every other cycle -> identical c, 72+ cycles, no extra bits consumed.
REQ-036 Abort after 20 bits, then load 36'h123456789 -> c goes 0 -> 36'h123456789, never an intermediate value.
REQ-037 rst asserted at bit 10 -> all outputs at reset values; a subsequent full load of 36'hFFFFFFFFF commits correctly.
REQ-038 With IO_CFG_PARITY_EN: frame 36'h000000001 with parity bit 1 -> commits; the same frame with parity bit 0 -> err=1, c unchanged, no done.
